// File: rtl/sdr_extract_pkg.sv
// Shared types and helpers for the SDR index extractor: FSM states, mode bit
// positions and a width-agnostic popcount.
package sdr_extract_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int MODE_COUNT = 0;
    localparam int MODE_DESC  = 1;

    // Widest row the popcount helper accepts; narrower rows are zero-extended.
    localparam int POP_MAX_W = 1024;

    function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] word);
        int unsigned cnt;
        cnt = 0;
        for (int i = 0; i < POP_MAX_W; i++) begin
            cnt = cnt + {31'd0, word[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/sdr_bit_pick.sv
// Combinational priority encoder over one SDR row: lowest set bit when
// ascending, highest set bit when descending.
module sdr_bit_pick #(
    parameter int ROW_WIDTH = 32,
    parameter int BIT_W     = $clog2(ROW_WIDTH)
) (
    input  logic [ROW_WIDTH-1:0] row_i,
    input  logic                 desc_i,
    output logic                 found_o,
    output logic [BIT_W-1:0]     bit_o
);

    always_comb begin
        // NOTE: every output gets a default first, so no path leaves it unassigned and no latch is inferred.
        found_o = |row_i;
        bit_o   = '0;
        if (desc_i) begin
            for (int i = 0; i < ROW_WIDTH; i++) begin
                if (row_i[i]) bit_o = BIT_W'(i);
            end
        end else begin
            for (int i = ROW_WIDTH - 1; i >= 0; i--) begin
                if (row_i[i]) bit_o = BIT_W'(i);
            end
        end
    end

endmodule

// File: rtl/sdr_index_extractor.sv
// Snapshots an SDR on start and either streams the flat indices of its set bits
// (capped at MAX_ACTIVE) over valid/ready, or returns only the popcount.
module sdr_index_extractor
    import sdr_extract_pkg::*;
#(
    parameter int NUM_ROWS   = 32,
    parameter int ROW_WIDTH  = 32,
    parameter int MAX_ACTIVE = 64,
    parameter int IDX_WIDTH  = $clog2(NUM_ROWS * ROW_WIDTH),
    parameter int CNT_WIDTH  = $clog2(NUM_ROWS * ROW_WIDTH + 1)
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                start_i,
    input  logic                                abort_i,
    input  logic [1:0]                          mode_i,
    input  logic [NUM_ROWS-1:0][ROW_WIDTH-1:0]  sdr_i,
    output logic                                idx_valid_o,
    input  logic                                idx_ready_i,
    output logic [IDX_WIDTH-1:0]                idx_o,
    output logic                                idx_last_o,
    output logic                                busy_o,
    output logic                                done_o,
    output logic [CNT_WIDTH-1:0]                active_count_o,
    output logic                                truncated_o,
    output logic                                err_start_busy_o
);

    localparam int                    PTR_W    = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int                    BIT_W    = $clog2(ROW_WIDTH);
    localparam logic [PTR_W-1:0]      PTR_LAST = PTR_W'(NUM_ROWS - 1);
    localparam logic [CNT_WIDTH-1:0]  CNT_CAP  = CNT_WIDTH'(MAX_ACTIVE);

    state_e                             state_q, state_d;
    logic [NUM_ROWS-1:0][ROW_WIDTH-1:0] sdr_q, sdr_d;
    logic [1:0]                         mode_q, mode_d;
    logic [PTR_W-1:0]                   ptr_q, ptr_d;
    logic [CNT_WIDTH-1:0]               count_q, count_d;
    logic                               trunc_q, trunc_d;
    logic                               err_q, err_d;

    logic [ROW_WIDTH-1:0]               cur_row;
    logic                               pick_found;
    logic [BIT_W-1:0]                   pick_bit;
    logic [NUM_ROWS-1:0][ROW_WIDTH-1:0] sdr_bit_clr, sdr_row_clr;
    logic                               count_mode, desc;
    logic                               sdr_empty, rest_empty, row_rest_empty;
    logic                               cap_hit, list_valid, list_last, handshake;
    logic [PTR_W-1:0]                   ptr_step;
    logic [IDX_WIDTH-1:0]               flat_idx;

    assign count_mode = mode_q[MODE_COUNT];
    assign desc       = mode_q[MODE_DESC];
    assign cur_row    = sdr_q[ptr_q];

    sdr_bit_pick #(
        .ROW_WIDTH (ROW_WIDTH),
        .BIT_W     (BIT_W)
    ) u_bit_pick (
        .row_i   (cur_row),
        .desc_i  (desc),
        .found_o (pick_found),
        .bit_o   (pick_bit)
    );

    // Buffer images after consuming the presented bit or the whole current row.
    always_comb begin
        sdr_bit_clr                  = sdr_q;
        sdr_bit_clr[ptr_q][pick_bit] = 1'b0;
        sdr_row_clr                  = sdr_q;
        sdr_row_clr[ptr_q]           = '0;
    end

    assign sdr_empty      = (sdr_q == '0);
    assign rest_empty     = (sdr_bit_clr == '0);
    assign row_rest_empty = (sdr_row_clr == '0);
    assign cap_hit        = ((count_q + CNT_WIDTH'(1)) == CNT_CAP);
    assign list_valid     = (state_q == SCAN) && !count_mode && pick_found;
    assign list_last      = rest_empty || cap_hit;
    assign handshake      = list_valid && idx_ready_i && !abort_i;
    assign ptr_step       = desc ? (ptr_q - PTR_W'(1)) : (ptr_q + PTR_W'(1));
    assign flat_idx       = IDX_WIDTH'(ptr_q) * IDX_WIDTH'(ROW_WIDTH) + IDX_WIDTH'(pick_bit);

    always_comb begin
        state_d = state_q;
        sdr_d   = sdr_q;
        mode_d  = mode_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        trunc_d = trunc_q;
        err_d   = err_q;

        if (start_i && (state_q != IDLE)) err_d = 1'b1;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    sdr_d   = sdr_i;
                    mode_d  = mode_i;
                    ptr_d   = mode_i[MODE_DESC] ? PTR_LAST : '0;
                    count_d = '0;
                    trunc_d = 1'b0;
                    err_d   = 1'b0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (sdr_empty) begin
                    state_d = DONE;
                end else if (count_mode) begin
                    count_d = count_q + CNT_WIDTH'(popcount(POP_MAX_W'(cur_row)));
                    sdr_d   = sdr_row_clr;
                    ptr_d   = ptr_step;
                    if (row_rest_empty) state_d = DONE;
                end else if (!pick_found) begin
                    ptr_d = ptr_step;
                end else if (handshake) begin
                    sdr_d   = sdr_bit_clr;
                    count_d = count_q + CNT_WIDTH'(1);
                    if (list_last) begin
                        state_d = DONE;
                        trunc_d = cap_hit && !rest_empty;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Abort discards whatever this cycle would have accumulated.
        if (abort_i && (state_q != IDLE)) begin
            state_d = IDLE;
            count_d = count_q;
            trunc_d = trunc_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // NOTE: the SDR buffer is reset too, so a stale snapshot never leaks into a later operation.
            state_q <= IDLE;
            sdr_q   <= '0;
            mode_q  <= '0;
            ptr_q   <= '0;
            count_q <= '0;
            trunc_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
            state_q <= state_d;
            sdr_q   <= sdr_d;
            mode_q  <= mode_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            trunc_q <= trunc_d;
            err_q   <= err_d;
        end
    end

    assign idx_valid_o      = list_valid;
    assign idx_o            = list_valid ? flat_idx : '0;
    assign idx_last_o       = list_valid && list_last;
    assign busy_o           = (state_q == SCAN);
    assign done_o           = (state_q == DONE) && !abort_i;
    assign active_count_o   = count_q;
    assign truncated_o      = trunc_q;
    assign err_start_busy_o = err_q;

endmodule

// File: tb/tb_sdr_index_extractor.sv
// Directed bench for sdr_index_extractor at default parameters: list and count
// modes, stalls, truncation, empty SDR, abort, start-while-busy and mid-scan reset.
module tb_sdr_index_extractor;

    logic                clk_i = 1'b0;
    logic                rst_i;
    logic                start_i;
    logic                abort_i;
    logic [1:0]          mode_i;
    logic [31:0][31:0]   sdr_i;
    logic                idx_valid_o;
    logic                idx_ready_i;
    logic [9:0]          idx_o;
    logic                idx_last_o;
    logic                busy_o;
    logic                done_o;
    logic [10:0]         active_count_o;
    logic                truncated_o;
    logic                err_start_busy_o;

    int passed = 0;
    int total  = 0;

    int   got_idx  [128];
    bit   got_last [128];
    int   got_n;
    bit   got_done;
    int   done_cycle;
    int   stall_err;
    bit   valid_seen;
    bit   busy_c1;
    int   got_count;
    bit   got_trunc;

    logic [31:0][31:0] sdr_sparse, sdr_ones, sdr_zero;

    sdr_index_extractor u_dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .start_i          (start_i),
        .abort_i          (abort_i),
        .mode_i           (mode_i),
        .sdr_i            (sdr_i),
        .idx_valid_o      (idx_valid_o),
        .idx_ready_i      (idx_ready_i),
        .idx_o            (idx_o),
        .idx_last_o       (idx_last_o),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .active_count_o   (active_count_o),
        .truncated_o      (truncated_o),
        .err_start_busy_o (err_start_busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Drives start for one cycle; returns at the start of cycle 1.
    task automatic start_op(input logic [1:0] m, input logic [31:0][31:0] s);
        @(posedge clk_i); #1;
        sdr_i   = s;
        mode_i  = m;
        start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
    endtask

    // Runs the operation until done_o or budget, recording handshakes and stalls.
    task automatic collect(input int budget, input bit toggle);
        bit            held_valid;
        logic [9:0]    held_idx;
        logic          held_last;
        got_n = 0; got_done = 0; done_cycle = -1; stall_err = 0;
        valid_seen = 0; busy_c1 = 0; held_valid = 0; held_idx = '0; held_last = 0;
        got_count = -1; got_trunc = 0;
        for (int c = 1; c <= budget; c++) begin
            idx_ready_i = toggle ? (c % 2 == 0) : 1'b1;
            @(negedge clk_i);
            if (c == 1) busy_c1 = busy_o;
            if (idx_valid_o) valid_seen = 1;
            if (held_valid && (!idx_valid_o || idx_o !== held_idx || idx_last_o !== held_last))
                stall_err++;
            held_valid = idx_valid_o && !idx_ready_i;
            held_idx   = idx_o;
            held_last  = idx_last_o;
            if (idx_valid_o && idx_ready_i && got_n < 128) begin
                got_idx[got_n]  = int'(idx_o);
                got_last[got_n] = idx_last_o;
                got_n++;
            end
            if (done_o) begin
                got_done   = 1;
                done_cycle = c;
                got_count  = int'(active_count_o);
                got_trunc  = truncated_o;
                break;
            end
            @(posedge clk_i); #1;
        end
        idx_ready_i = 1'b1;
    endtask

    task automatic test_reset;
        rst_i = 1'b1; start_i = 0; abort_i = 0; mode_i = 0; sdr_i = '0; idx_ready_i = 0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        total++; if (idx_valid_o !== 1'b0) $display("FAIL reset_valid: got %0b expected 0", idx_valid_o); else passed++;
        total++; if (busy_o !== 1'b0) $display("FAIL reset_busy: got %0b expected 0", busy_o); else passed++;
        total++; if (done_o !== 1'b0) $display("FAIL reset_done: got %0b expected 0", done_o); else passed++;
        total++; if (active_count_o !== 11'd0) $display("FAIL reset_count: got %0d expected 0", active_count_o); else passed++;
        total++; if ({truncated_o, err_start_busy_o, idx_last_o} !== 3'b000)
            $display("FAIL reset_flags: got %b expected 000", {truncated_o, err_start_busy_o, idx_last_o}); else passed++;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
    endtask

    task automatic test_asc_list;
        start_op(2'b00, sdr_sparse);
        collect(200, 0);
        total++; if (got_done !== 1'b1) $display("FAIL asc_done: got %0b expected 1", got_done); else passed++;
        total++; if (busy_c1 !== 1'b1) $display("FAIL asc_busy_c1: got %0b expected 1", busy_c1); else passed++;
        total++; if (got_n !== 3) $display("FAIL asc_n: got %0d expected 3", got_n); else passed++;
        total++; if (got_idx[0] !== 0 || got_idx[1] !== 2 || got_idx[2] !== 63)
            $display("FAIL asc_idx: got %0d,%0d,%0d expected 0,2,63", got_idx[0], got_idx[1], got_idx[2]); else passed++;
        total++; if ({got_last[0], got_last[1], got_last[2]} !== 3'b001)
            $display("FAIL asc_last: got %b expected 001", {got_last[0], got_last[1], got_last[2]}); else passed++;
        total++; if (done_cycle !== 5) $display("FAIL asc_done_cycle: got %0d expected 5", done_cycle); else passed++;
        total++; if (got_count !== 3) $display("FAIL asc_count: got %0d expected 3", got_count); else passed++;
        @(posedge clk_i); #1;
        @(negedge clk_i);
        total++; if (active_count_o !== 11'd3 || busy_o !== 1'b0 || done_o !== 1'b0)
            $display("FAIL asc_hold: got count=%0d busy=%0b done=%0b expected 3/0/0", active_count_o, busy_o, done_o); else passed++;
    endtask

    task automatic test_desc_stall;
        start_op(2'b10, sdr_sparse);
        collect(200, 1);
        total++; if (got_n !== 3 || got_idx[0] !== 63 || got_idx[1] !== 2 || got_idx[2] !== 0)
            $display("FAIL desc_idx: got n=%0d %0d,%0d,%0d expected 3 63,2,0", got_n, got_idx[0], got_idx[1], got_idx[2]); else passed++;
        total++; if (got_last[2] !== 1'b1 || got_last[0] !== 1'b0)
            $display("FAIL desc_last: got %b expected 001", {got_last[0], got_last[1], got_last[2]}); else passed++;
        total++; if (stall_err !== 0) $display("FAIL desc_stable: got %0d stall changes expected 0", stall_err); else passed++;
        total++; if (got_done !== 1'b1 || got_count !== 3)
            $display("FAIL desc_count: got done=%0b count=%0d expected 1/3", got_done, got_count); else passed++;
    endtask

    task automatic test_asc_all_trunc;
        int seq_err;
        start_op(2'b00, sdr_ones);
        collect(500, 0);
        seq_err = 0;
        for (int i = 0; i < 64; i++) begin
            if (got_idx[i] !== i) seq_err++;
            if (got_last[i] !== (i == 63)) seq_err++;
        end
        total++; if (got_n !== 64) $display("FAIL trunc_n: got %0d expected 64", got_n); else passed++;
        total++; if (seq_err !== 0) $display("FAIL trunc_seq: got %0d bad entries expected 0", seq_err); else passed++;
        total++; if (got_trunc !== 1'b1) $display("FAIL trunc_flag: got %0b expected 1", got_trunc); else passed++;
        total++; if (got_count !== 64) $display("FAIL trunc_count: got %0d expected 64", got_count); else passed++;
    endtask

    task automatic test_count_all;
        start_op(2'b01, sdr_ones);
        collect(200, 0);
        total++; if (valid_seen !== 1'b0) $display("FAIL cnt_no_valid: got %0b expected 0", valid_seen); else passed++;
        total++; if (got_count !== 1024) $display("FAIL cnt_count: got %0d expected 1024", got_count); else passed++;
        total++; if (done_cycle !== 33) $display("FAIL cnt_done_cycle: got %0d expected 33", done_cycle); else passed++;
        total++; if (got_trunc !== 1'b0) $display("FAIL cnt_trunc: got %0b expected 0", got_trunc); else passed++;
    endtask

    task automatic test_empty;
        start_op(2'b00, sdr_zero);
        collect(50, 0);
        total++; if (done_cycle !== 2) $display("FAIL empty_done_cycle: got %0d expected 2", done_cycle); else passed++;
        total++; if (got_n !== 0 || valid_seen !== 1'b0)
            $display("FAIL empty_valid: got n=%0d valid=%0b expected 0/0", got_n, valid_seen); else passed++;
        total++; if (got_count !== 0 || got_trunc !== 1'b0)
            $display("FAIL empty_count: got %0d trunc=%0b expected 0/0", got_count, got_trunc); else passed++;
    endtask

    task automatic test_abort_err;
        start_op(2'b00, sdr_ones);
        idx_ready_i = 1'b1;
        @(negedge clk_i);
        total++; if (idx_valid_o !== 1'b1 || idx_o !== 10'd0)
            $display("FAIL abort_first: got valid=%0b idx=%0d expected 1/0", idx_valid_o, idx_o); else passed++;
        @(posedge clk_i); #1;
        start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        abort_i = 1'b1;
        @(negedge clk_i);
        total++; if (done_o !== 1'b0) $display("FAIL abort_no_done: got %0b expected 0", done_o); else passed++;
        @(posedge clk_i); #1;
        abort_i = 1'b0;
        @(negedge clk_i);
        total++; if (busy_o !== 1'b0 || idx_valid_o !== 1'b0 || done_o !== 1'b0)
            $display("FAIL abort_idle: got busy=%0b valid=%0b done=%0b expected 0/0/0", busy_o, idx_valid_o, done_o); else passed++;
        total++; if (active_count_o !== 11'd2) $display("FAIL abort_count: got %0d expected 2", active_count_o); else passed++;
        total++; if (err_start_busy_o !== 1'b1) $display("FAIL err_busy: got %0b expected 1", err_start_busy_o); else passed++;
    endtask

    task automatic test_reset_mid_scan;
        start_op(2'b00, sdr_ones);
        idx_ready_i = 1'b1;
        @(negedge clk_i);
        total++; if (err_start_busy_o !== 1'b0) $display("FAIL err_cleared: got %0b expected 0", err_start_busy_o); else passed++;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        idx_ready_i = 1'b0;
        start_i     = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        @(negedge clk_i);
        total++; if (idx_valid_o !== 1'b1 || active_count_o !== 11'd2 || err_start_busy_o !== 1'b1)
            $display("FAIL rst_pre: got valid=%0b count=%0d err=%0b expected 1/2/1", idx_valid_o, active_count_o, err_start_busy_o); else passed++;
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        total++; if ({idx_valid_o, idx_last_o, busy_o, done_o, truncated_o, err_start_busy_o} !== 6'b0 ||
                     active_count_o !== 11'd0 || idx_o !== 10'd0)
            $display("FAIL rst_mid: got flags=%b count=%0d idx=%0d expected 000000/0/0",
                     {idx_valid_o, idx_last_o, busy_o, done_o, truncated_o, err_start_busy_o}, active_count_o, idx_o);
        else passed++;
    endtask

    initial begin
        sdr_zero      = '0;
        sdr_ones      = '1;
        sdr_sparse    = '0;
        sdr_sparse[0] = 32'h0000_0005;
        sdr_sparse[1] = 32'h8000_0000;

        test_reset();
        test_asc_list();
        test_desc_stall();
        test_asc_all_trunc();
        test_count_all();
        test_empty();
        test_abort_err();
        test_reset_mid_scan();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
